// File: rtl/fpu_wb_select_pkg.sv
// Shared types and source-code constants for the FPU write-back selector.
package fpu_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } wb_state_t;

  localparam int SEL_NONE = 0;

  // Default mapping of select codes to functional units (code = source index + 1).
  localparam int ADD  = 1;
  localparam int SUB  = 2;
  localparam int MUL  = 3;
  localparam int NEG  = 4;
  localparam int ABS  = 5;
  localparam int SINE = 6;
  localparam int SRAM = 7;
  localparam int MOV  = 8;

endpackage

// File: rtl/fpu_wb_select_if.sv
// Issue / source-result / register-file write bundle for the write-back selector.
interface fpu_wb_select_if
  import fpu_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 8,
  parameter int SEL_W  = 4,
  parameter int ADDR_W = 4
);

  logic                     issue;
  logic [SEL_W-1:0]         issue_sel;
  logic [ADDR_W-1:0]        issue_addr;
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC*DATA_W-1:0]  src_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     busy;
  logic                     done;
  logic                     err;

  // Master: issuer plus functional units; slave: the selector itself.
  modport master (
    output issue, issue_sel, issue_addr, src_valid, src_data,
    input  wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  issue, issue_sel, issue_addr, src_valid, src_data,
    output wr_en, wr_addr, wr_data, busy, done, err
  );

endinterface

// File: rtl/fpu_wb_select_wait_timer.sv
// Clear/enable wait counter; terminal is high once the count has reached TIMEOUT.
module wb_wait_timer
  import fpu_wb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count_reg;

  assign terminal = (count_reg == CNT_W'(TIMEOUT));

  // Saturates at TIMEOUT so terminal stays asserted until the next clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !terminal) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fpu_wb_select.sv
// Handshaked write-back selector: waits for the chosen unit's valid, captures its
// result and issues one registered register-file write, with a wait timeout.
module fpu_wb_select
  import fpu_wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_SRC   = 8,
  parameter int SEL_W   = 4,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            n_rst,
  fpu_wb_select_if.slave  bus
);

  localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BASE_W = (N_SRC * DATA_W > 1) ? $clog2(N_SRC * DATA_W) : 1;
  localparam logic [SEL_W-1:0] MAX_CODE = SEL_W'(N_SRC);

  wb_state_t         state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              wr_en_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic              code_none;
  logic              code_ok;
  logic              accept;
  logic              sel_valid;
  logic [BASE_W-1:0] sel_base;
  logic [DATA_W-1:0] sel_data;
  logic              timer_en;
  logic              timer_term;

  assign code_none = (bus.issue_sel == SEL_W'(SEL_NONE));
  assign code_ok   = !code_none && (bus.issue_sel <= MAX_CODE);
  // The done cycle of a write still accepts a new request; only WAIT drops issues.
  assign accept    = bus.issue && (state_reg != WAIT) && code_ok;

  assign sel_valid = bus.src_valid[idx_reg];
  assign sel_base  = BASE_W'(idx_reg) * BASE_W'(DATA_W);
  assign sel_data  = bus.src_data[sel_base +: DATA_W];
  assign timer_en  = (state_reg == WAIT) && !sel_valid;

  wb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (accept),
    .enable   (timer_en),
    .terminal (timer_term)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      addr_reg    <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        WAIT: begin
          // Valid takes priority over a coinciding timeout.
          if (sel_valid) begin
            wr_data_reg <= sel_data;
            wr_addr_reg <= addr_reg;
            wr_en_reg   <= 1'b1;
            done_reg    <= 1'b1;
            state_reg   <= WRITE;
          end else if (timer_term) begin
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (bus.issue) begin
            if (code_none) begin
              done_reg <= 1'b1;
            end else if (code_ok) begin
              idx_reg   <= IDX_W'(bus.issue_sel - SEL_W'(1));
              addr_reg  <= bus.issue_addr;
              busy_reg  <= 1'b1;
              state_reg <= WAIT;
            end else begin
              done_reg <= 1'b1;
              err_reg  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;

endmodule
